// File: rtl/vga_pkg.sv
`default_nettype none
// vga_pkg: screen geometry constants and the drawer state encoding shared by all VGA drawers.
// Revision 1.0
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drawer_state_e;
endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// raster_counter: row-major (cx, cy) scan with a linear address kept as a running counter.
// Revision 1.0
module raster_counter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              enable_i,
  output logic [X_W-1:0]    cx_o,
  output logic [Y_W-1:0]    cy_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  localparam logic [X_W-1:0] C_XMAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] C_YMAX = Y_W'(HEIGHT - 1);

  logic [X_W-1:0]    cx_q;
  logic [Y_W-1:0]    cy_q;
  logic [ADDR_W-1:0] addr_q;

  assign last_o = (cx_q == C_XMAX) && (cy_q == C_YMAX);
  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign addr_o = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx_q   <= '0;
      cy_q   <= '0;
      addr_q <= '0;
    end else if (clear_i) begin
      cx_q   <= '0;
      cy_q   <= '0;
      addr_q <= '0;
    end else if (enable_i) begin
      // Wrapping on the last pixel keeps every counter inside the frame.
      if (cx_q == C_XMAX) begin
        cx_q <= '0;
        cy_q <= (cy_q == C_YMAX) ? '0 : cy_q + 1'b1;
      end else begin
        cx_q <= cx_q + 1'b1;
      end
      addr_q <= last_o ? '0 : addr_q + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/bg_sweep_drawer.sv
`default_nettype none
// bg_sweep_drawer: rasters the full frame from a 1-cycle background ROM into the VGA adapter.
// Revision 1.0; define BG_SOLID_FILL_EN for a solid fill_colour clear instead of ROM colour.
module bg_sweep_drawer #(
  parameter int WIDTH    = vga_pkg::SCREEN_W,
  parameter int HEIGHT   = vga_pkg::SCREEN_H,
  parameter int X_W      = vga_pkg::X_W,
  parameter int Y_W      = vga_pkg::Y_W,
  parameter int COLOUR_W = vga_pkg::COLOUR_W,
  parameter int ADDR_W   = vga_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_BG,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
`ifdef BG_SOLID_FILL_EN
  input  logic [COLOUR_W-1:0] fill_colour,
`endif
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                draw,
  output logic                busy
);
  import vga_pkg::*;

  drawer_state_e        state_q;
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;
  logic [COLOUR_W-1:0]  colour_q;
  logic                 plot_q;
  logic                 draw_q;
  logic                 busy_q;

  logic [X_W-1:0]       cx;
  logic [Y_W-1:0]       cy;
  logic [ADDR_W-1:0]    scan_addr;
  logic                 scan_last;
  logic                 scan_clear;
  logic                 scan_adv;

  assign scan_clear = (state_q == ST_IDLE);
  assign scan_adv   = (state_q == ST_SWEEP) && ld_BG;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (scan_clear),
    .enable_i (scan_adv),
    .cx_o     (cx),
    .cy_o     (cy),
    .addr_o   (scan_addr),
    .last_o   (scan_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      draw_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      plot_q <= 1'b0;
`ifndef BG_SOLID_FILL_EN
      // Latch the pixel just shown so colour holds once plot drops.
      if (plot_q) colour_q <= rom_data;
`endif
      case (state_q)
        ST_IDLE: begin
          draw_q <= 1'b0;
          if (ld_BG) begin
            state_q <= ST_SWEEP;
            busy_q  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (!ld_BG) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            plot_q <= 1'b1;
            x_q    <= cx;
            y_q    <= cy;
`ifdef BG_SOLID_FILL_EN
            colour_q <= fill_colour;
`endif
            if (scan_last) state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          busy_q <= 1'b0;
          if (!ld_BG) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
            draw_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!ld_BG) begin
            state_q <= ST_IDLE;
            draw_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BG_SOLID_FILL_EN
  assign rom_addr = '0;
  assign colour   = colour_q;
`else
  assign rom_addr = scan_addr;
  assign colour   = plot_q ? rom_data : colour_q;
`endif
  assign x    = x_q;
  assign y    = y_q;
  assign plot = plot_q;
  assign draw = draw_q;
  assign busy = busy_q;
endmodule
`default_nettype wire
